// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-port integer register file with two combinational read
// ports, two prioritised write-back ports (wb1 over wb0) and a per-register busy
// scoreboard for hazard detection. Register 0 is optionally hard-wired to zero.
// Optional feature: define RF_BYPASS_EN for same-cycle write-to-read bypass.
module register_bank_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb0_en,
    input  logic [AW-1:0]   wb0_rd,
    input  logic [XLEN-1:0] wb0_value,
    input  logic            wb1_en,
    input  logic [AW-1:0]   wb1_rd,
    input  logic [XLEN-1:0] wb1_value,
    output logic            wr_conflict
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic wr_conflict_q, wr_conflict_d;

    // Accesses to a hard-wired x0 are squashed before they reach any state.
    logic wb0_ok, wb1_ok, iss_ok;
    assign wb0_ok = wb0_en && !(ZERO_REG && (wb0_rd == '0));
    assign wb1_ok = wb1_en && !(ZERO_REG && (wb1_rd == '0));
    assign iss_ok = issue_valid && !(ZERO_REG && (issue_rd == '0));

    // Next-state: wb1 overrides wb0; issue wins over write-back on the busy bit.
    always_comb begin
        regs_d        = regs_q;
        busy_d        = busy_q;
        wr_conflict_d = wb0_ok && wb1_ok && (wb0_rd == wb1_rd);
        if (wb0_ok) begin
            regs_d[wb0_rd] = wb0_value;
            busy_d[wb0_rd] = 1'b0;
        end
        if (wb1_ok) begin
            regs_d[wb1_rd] = wb1_value;
            busy_d[wb1_rd] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q        <= '{default: '0};
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    logic [AW-1:0]   rs_idx [2];
    logic [XLEN-1:0] rd_val [2];
    logic            rd_bsy [2];

    assign rs_idx[0] = rs1;
    assign rs_idx[1] = rs2;

    // Read ports: flop state, optionally overridden by this cycle's write-back.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = regs_q[rs_idx[p]];
            rd_bsy[p] = busy_q[rs_idx[p]];
`ifdef RF_BYPASS_EN
            if ((wb0_ok && (wb0_rd == rs_idx[p])) || (wb1_ok && (wb1_rd == rs_idx[p]))) begin
                rd_val[p] = (wb1_ok && (wb1_rd == rs_idx[p])) ? wb1_value : wb0_value;
                rd_bsy[p] = iss_ok && (issue_rd == rs_idx[p]);
            end
`endif
            if (ZERO_REG && (rs_idx[p] == '0)) begin
                rd_val[p] = '0;
                rd_bsy[p] = 1'b0;
            end
        end
    end

    assign rs1_value   = rd_val[0];
    assign rs2_value   = rd_val[1];
    assign rs1_busy    = rd_bsy[0];
    assign rs2_busy    = rd_bsy[1];
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: a default instance (32x32, x0 hard-wired) and a
// 64-bit, 16-entry instance with an ordinary x0, both driven by the same stimulus
// and compared against an array-based model of the register/busy rules.
module tb_register_bank_mp;

`ifdef RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk, rst;
    logic [4:0]  rs1, rs2, issue_rd, wb0_rd, wb1_rd;
    logic        issue_valid, wb0_en, wb1_en;
    logic [63:0] wb0_value, wb1_value;

    logic [31:0] a_rs1_value, a_rs2_value;
    logic        a_rs1_busy, a_rs2_busy, a_wr_conflict;
    logic [63:0] b_rs1_value, b_rs2_value;
    logic        b_rs1_busy, b_rs2_busy, b_wr_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    register_bank_mp dut_a (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2),
        .rs1_value(a_rs1_value), .rs2_value(a_rs2_value),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_value(wb0_value[31:0]),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_value(wb1_value[31:0]),
        .wr_conflict(a_wr_conflict)
    );

    register_bank_mp #(.XLEN(64), .NREGS(16), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .rs1(rs1[3:0]), .rs2(rs2[3:0]),
        .rs1_value(b_rs1_value), .rs2_value(b_rs2_value),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd[3:0]),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd[3:0]), .wb0_value(wb0_value),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd[3:0]), .wb1_value(wb1_value),
        .wr_conflict(b_wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = instance a, index 1 = instance b.
    logic [63:0] m_regs [2][32];
    logic        m_busy [2][32];
    logic        m_conf [2];
    bit          zr   [2] = '{1'b1, 1'b0};
    logic [63:0] mask [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ix(int k, logic [4:0] i);
        return (k == 1) ? int'(i[3:0]) : int'(i);
    endfunction

    function automatic bit hits(int k, logic en, logic [4:0] rd, logic [4:0] i);
        return en && (ix(k, rd) == ix(k, i)) && !(zr[k] && ix(k, rd) == 0);
    endfunction

    function automatic logic [63:0] exp_val(int k, logic [4:0] i);
        if (zr[k] && ix(k, i) == 0) return 64'h0;
        if (Byp && hits(k, wb1_en, wb1_rd, i)) return wb1_value & mask[k];
        if (Byp && hits(k, wb0_en, wb0_rd, i)) return wb0_value & mask[k];
        return m_regs[k][ix(k, i)];
    endfunction

    function automatic logic exp_bsy(int k, logic [4:0] i);
        if (zr[k] && ix(k, i) == 0) return 1'b0;
        if (Byp && (hits(k, wb1_en, wb1_rd, i) || hits(k, wb0_en, wb0_rd, i)))
            return hits(k, issue_valid, issue_rd, i);
        return m_busy[k][ix(k, i)];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_conf[k] = 1'b0;
            for (int r = 0; r < 32; r++) begin
                m_regs[k][r] = 64'h0;
                m_busy[k][r] = 1'b0;
            end
        end
    endtask

    task automatic model_update(int k);
        bit w0, w1, iv;
        w0 = wb0_en && !(zr[k] && ix(k, wb0_rd) == 0);
        w1 = wb1_en && !(zr[k] && ix(k, wb1_rd) == 0);
        iv = issue_valid && !(zr[k] && ix(k, issue_rd) == 0);
        m_conf[k] = w0 && w1 && (ix(k, wb0_rd) == ix(k, wb1_rd));
        if (w0) begin
            m_regs[k][ix(k, wb0_rd)] = wb0_value & mask[k];
            m_busy[k][ix(k, wb0_rd)] = 1'b0;
        end
        if (w1) begin
            m_regs[k][ix(k, wb1_rd)] = wb1_value & mask[k];
            m_busy[k][ix(k, wb1_rd)] = 1'b0;
        end
        if (iv) m_busy[k][ix(k, issue_rd)] = 1'b1;
    endtask

    task automatic check_outputs();
        check_eq("a_rs1_value", {32'h0, a_rs1_value}, exp_val(0, rs1));
        check_eq("a_rs2_value", {32'h0, a_rs2_value}, exp_val(0, rs2));
        check_eq("a_rs1_busy", {63'h0, a_rs1_busy}, {63'h0, exp_bsy(0, rs1)});
        check_eq("a_rs2_busy", {63'h0, a_rs2_busy}, {63'h0, exp_bsy(0, rs2)});
        check_eq("a_wr_conflict", {63'h0, a_wr_conflict}, {63'h0, m_conf[0]});
        check_eq("b_rs1_value", b_rs1_value, exp_val(1, rs1));
        check_eq("b_rs2_value", b_rs2_value, exp_val(1, rs2));
        check_eq("b_rs1_busy", {63'h0, b_rs1_busy}, {63'h0, exp_bsy(1, rs1)});
        check_eq("b_rs2_busy", {63'h0, b_rs2_busy}, {63'h0, exp_bsy(1, rs2)});
        check_eq("b_wr_conflict", {63'h0, b_wr_conflict}, {63'h0, m_conf[1]});
    endtask

    task automatic drive(logic iv, logic [4:0] ird, logic w0e, logic [4:0] w0rd,
                         logic [63:0] w0v, logic w1e, logic [4:0] w1rd, logic [63:0] w1v,
                         logic [4:0] r1, logic [4:0] r2);
        issue_valid = iv;  issue_rd  = ird;
        wb0_en = w0e;      wb0_rd = w0rd; wb0_value = w0v;
        wb1_en = w1e;      wb1_rd = w1rd; wb1_value = w1v;
        rs1 = r1;          rs2 = r2;
    endtask

    // Idle write/issue ports, select read indices, let combinational reads settle.
    task automatic peek(logic [4:0] r1, logic [4:0] r2);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, r1, r2);
        #1;
    endtask

    // Check outputs against the model, then clock one edge into both DUT and model.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_idx();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    logic [63:0] old12;

    initial begin
        rst = 1'b1;
        model_reset();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
        #1;
        check_eq("reset_a_value", {32'h0, a_rs1_value}, 64'h0);
        check_eq("reset_b_value", b_rs1_value, 64'h0);
        check_eq("reset_a_busy", {63'h0, a_rs1_busy}, 64'h0);
        check_eq("reset_conflict", {63'h0, a_wr_conflict}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Dual write to distinct registers, then a same-register collision.
        drive(1'b0, 5'd0, 1'b1, 5'd7, 64'h11, 1'b1, 5'd9, 64'h22, 5'd7, 5'd9);
        tick();
        peek(5'd7, 5'd9);
        check_eq("dual_x7", {32'h0, a_rs1_value}, 64'h11);
        check_eq("dual_x9", {32'h0, a_rs2_value}, 64'h22);
        check_eq("dual_noconf", {63'h0, a_wr_conflict}, 64'h0);
        drive(1'b0, 5'd0, 1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB, 5'd3, 5'd3);
        tick();
        peek(5'd3, 5'd0);
        check_eq("coll_x3", {32'h0, a_rs1_value}, 64'hBB);
        check_eq("coll_conf", {63'h0, a_wr_conflict}, 64'h1);
        tick();
        check_eq("coll_conf_pulse", {63'h0, a_wr_conflict}, 64'h0);

        // x0: hard-wired on instance a, ordinary on instance b.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
        tick();
        peek(5'd0, 5'd0);
        check_eq("x0_a_value", {32'h0, a_rs1_value}, 64'h0);
        check_eq("x0_a_busy", {63'h0, a_rs1_busy}, 64'h0);
        check_eq("x0_b_value", b_rs1_value, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("x0_b_busy", {63'h0, b_rs1_busy}, 64'h1);
        tick();

        // Scoreboard: issue, re-issue during write-back, then final write-back.
        drive(1'b1, 5'd4, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd4, 5'd4);
        tick();
        peek(5'd4, 5'd4);
        check_eq("sb_issue", {63'h0, a_rs1_busy}, 64'h1);
        drive(1'b1, 5'd4, 1'b1, 5'd4, 64'h5, 1'b0, 5'd0, 64'h0, 5'd4, 5'd4);
        tick();
        peek(5'd4, 5'd4);
        check_eq("sb_reissue", {63'h0, a_rs1_busy}, 64'h1);
        check_eq("sb_value", {32'h0, a_rs1_value}, 64'h5);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 64'h6, 5'd4, 5'd4);
        tick();
        peek(5'd4, 5'd4);
        check_eq("sb_clear", {63'h0, a_rs1_busy}, 64'h0);

        // Bypass: write-back and read of x12 in the same cycle.
        old12 = m_regs[0][12];
        drive(1'b0, 5'd0, 1'b1, 5'd12, 64'h1234, 1'b0, 5'd0, 64'h0, 5'd0, 5'd12);
        #1;
        check_eq("byp_same_cycle", {32'h0, a_rs2_value}, Byp ? 64'h1234 : old12);
        tick();
        peek(5'd0, 5'd12);
        check_eq("byp_next_cycle", {32'h0, a_rs2_value}, 64'h1234);

        // Wide instance: 64-bit round trip at x15, busy on all 16 entries.
        drive(1'b0, 5'd0, 1'b1, 5'd15, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 64'h0, 5'd15, 5'd15);
        tick();
        peek(5'd15, 5'd15);
        check_eq("wide_x15", b_rs1_value, 64'h0123_4567_89AB_CDEF);
        for (int r = 0; r < 16; r++) begin
            drive(1'b1, 5'(r), 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'(r), 5'd0);
            tick();
        end
        for (int r = 0; r < 16; r++) begin
            peek(5'(r), 5'(r));
            check_eq("wide_busy_all", {63'h0, b_rs1_busy}, 64'h1);
        end

        // Asynchronous reset mid-cycle after a colliding write to x5.
        drive(1'b1, 5'd6, 1'b1, 5'd5, 64'h1, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd6);
        tick();
        peek(5'd5, 5'd6);
        check_eq("pre_rst_x5", {32'h0, a_rs1_value}, 64'hDEAD_BEEF);
        check_eq("pre_rst_conf", {63'h0, a_wr_conflict}, 64'h1);
        check_eq("pre_rst_busy", {63'h0, a_rs2_busy}, 64'h1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_x5", {32'h0, a_rs1_value}, 64'h0);
        check_eq("rst_busy", {63'h0, a_rs2_busy}, 64'h0);
        check_eq("rst_b_busy", {63'h0, b_rs2_busy}, 64'h0);
        check_eq("rst_conf", {63'h0, a_wr_conflict}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), rand_idx(),
                  1'($urandom_range(0, 1)), rand_idx(), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), rand_idx(), {$urandom, $urandom},
                  rand_idx(), rand_idx());
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
